// File: rtl/main_control_pkg.sv
// Shared types for the multi-cycle main controller: FSM states, instruction type codes
// and the bit positions of the instruction fields.
package main_control_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  localparam logic [1:0] TYPE_A = 2'b00;
  localparam logic [1:0] TYPE_B = 2'b01;
  localparam logic [1:0] TYPE_C = 2'b10;
  localparam logic [1:0] TYPE_D = 2'b11;

  localparam int TYPE_HI  = 15;
  localparam int TYPE_LO  = 14;
  localparam int LS_BIT   = 12;
  localparam int FUNCT_HI = 3;
  localparam int FUNCT_LO = 0;

endpackage

// File: rtl/mem_timeout_counter.sv
// 8-bit down-counter that times the MEM handshake; load presets it, en counts down
// and it sticks at zero, where expired is flagged.
module mem_timeout_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 8'd0);

endmodule

// File: rtl/main_control.sv
// Multi-cycle main controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT with a timed memory handshake.
// Define MAIN_CONTROL_PERF_EN to get a retired-instruction counter on instr_count.
module main_control
  import main_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero_flag,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  alu_op,
  output logic [3:0]  funct_code,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  // The counter is preset one short so MEM lasts exactly MEM_TIMEOUT cycles.
  localparam logic [7:0] TIMEOUT_LOAD = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [3:0]  funct_q, funct_d;
  logic        fault_q, fault_d;
  logic        cnt_load, cnt_en, cnt_expired;

  logic [1:0]  ir_type;
  logic        ir_store;
  logic        unused_ir;

  assign ir_type   = ir_q[TYPE_HI:TYPE_LO];
  assign ir_store  = ir_q[LS_BIT];
  assign unused_ir = ^{ir_q[13], ir_q[11:4]};

  mem_timeout_counter u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (TIMEOUT_LOAD),
    .en       (cnt_en),
    .expired  (cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    alu_op_d    = alu_op_q;
    funct_d     = funct_q;
    fault_d     = fault_q;
    instr_ready = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_req     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          ir_d     = instr;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_op_d = ir_type;
        funct_d  = (ir_type == TYPE_A) ? ir_q[FUNCT_HI:FUNCT_LO] : 4'b0000;
        state_d  = (ir_type == TYPE_D) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        case (ir_type)
          TYPE_A: state_d = WRITEBACK;
          TYPE_B: begin
            cnt_load = 1'b1;
            state_d  = MEM;
          end
          TYPE_C: begin
            branch   = 1'b1;
            pc_write = zero_flag;
            state_d  = FETCH;
          end
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_read  = ~ir_store;
        mem_write = ir_store;
        cnt_en    = 1'b1;
        // An ack in the expiry cycle still completes the access.
        if (mem_ack) begin
          state_d = ir_store ? FETCH : WRITEBACK;
        end else if (cnt_expired) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      ir_q     <= 16'h0000;
      alu_op_q <= 2'b00;
      funct_q  <= 4'b0000;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      alu_op_q <= alu_op_d;
      funct_q  <= funct_d;
      fault_q  <= fault_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign funct_code = funct_q;
  assign fault      = fault_q;
  assign halted     = (state_q == HALT);

`ifdef MAIN_CONTROL_PERF_EN
  logic [15:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if ((state_d == FETCH) &&
        ((state_q == EXECUTE) || (state_q == MEM) || (state_q == WRITEBACK))) begin
      instr_count_d = instr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count_q <= 16'h0000;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule
